// File: rtl/branch_redirect_ctrl.sv
// Fetch-PC sequencer: redirects the PC on taken JAL/JALR/Bxx and squashes younger stages.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned targets to TRAP_VECTOR.
module branch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
`ifdef MISALIGN_TRAP_EN
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004,
`endif
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        ex_valid_in,
    input  logic [4:0]  opcode_6_to_2_in,
    input  logic        branch_taken_in,
    input  logic [31:0] ex_pc_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] imm_in,
    output logic [31:0] pc_out,
    output logic        flush_out,
    output logic        redirect_out,
    output logic        misaligned_out
);

    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [4:0] OP_JALR = 5'b11001;
    localparam logic [4:0] OP_BXX  = 5'b11000;
    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t      r_state, w_stateNext;
    logic [31:0] r_pc, w_pcNext;
    logic        r_flush, w_flushNext;
    logic        r_redirect, w_redirectNext;
    logic        r_misaligned, w_misalignedNext;
    logic [2:0]  r_cnt, w_cntNext;

    logic        w_isCti;
    logic        w_take;
    logic [31:0] w_sum;
    logic [31:0] w_target;
    logic [31:0] w_loadPc;
    logic        w_misFlag;

    assign w_isCti = (opcode_6_to_2_in == OP_JAL) || (opcode_6_to_2_in == OP_JALR) ||
                     (opcode_6_to_2_in == OP_BXX);
    assign w_take  = ex_valid_in && branch_taken_in && (r_state == ST_RUN) && w_isCti;

    // JALR is register-relative with bit 0 cleared; JAL and Bxx are PC-relative.
    always_comb begin
        if (opcode_6_to_2_in == OP_JALR) begin
            w_sum    = rs1_in + imm_in;
            w_target = w_sum & ~32'h1;
        end else begin
            w_sum    = ex_pc_in + imm_in;
            w_target = w_sum;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign w_misFlag = (w_target[1:0] != 2'b00);
    assign w_loadPc  = w_misFlag ? TRAP_VECTOR : w_target;
`else
    assign w_misFlag = 1'b0;
    assign w_loadPc  = w_target & ~32'h3;
`endif

    // A stall freezes everything; only the one-cycle pulses fall back to zero.
    always_comb begin
        w_stateNext      = r_state;
        w_pcNext         = r_pc;
        w_flushNext      = r_flush;
        w_cntNext        = r_cnt;
        w_redirectNext   = 1'b0;
        w_misalignedNext = 1'b0;
        if (!stall_in) begin
            case (r_state)
                ST_RUN: begin
                    if (w_take) begin
                        w_pcNext         = w_loadPc;
                        w_redirectNext   = 1'b1;
                        w_misalignedNext = w_misFlag;
                        w_flushNext      = 1'b1;
                        w_cntNext        = CNT_INIT;
                        w_stateNext      = ST_FLUSH;
                    end else begin
                        w_pcNext    = r_pc + 32'd4;
                        w_flushNext = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    w_pcNext = r_pc + 32'd4;
                    if (r_cnt == 3'd0) begin
                        w_stateNext = ST_RUN;
                        w_flushNext = 1'b0;
                    end else begin
                        w_cntNext = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_stateNext = ST_RUN;
                    w_flushNext = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_flush      <= 1'b0;
            r_redirect   <= 1'b0;
            r_misaligned <= 1'b0;
            r_cnt        <= 3'd0;
        end else begin
            r_state      <= w_stateNext;
            r_pc         <= w_pcNext;
            r_flush      <= w_flushNext;
            r_redirect   <= w_redirectNext;
            r_misaligned <= w_misalignedNext;
            r_cnt        <= w_cntNext;
        end
    end

    assign pc_out         = r_pc;
    assign flush_out      = r_flush;
    assign redirect_out   = r_redirect;
    assign misaligned_out = r_misaligned;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_branch_redirect_ctrl;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0004;
    localparam int          FLUSH_CYCLES = 2;
    localparam logic [4:0]  OP_JAL  = 5'b11011;
    localparam logic [4:0]  OP_JALR = 5'b11001;
    localparam logic [4:0]  OP_BXX  = 5'b11000;
    localparam logic [4:0]  OP_ADD  = 5'b01100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        exValid = 1'b0;
    logic [4:0]  opcode = 5'b0;
    logic        taken = 1'b0;
    logic [31:0] exPc = 32'h0;
    logic [31:0] rs1 = 32'h0;
    logic [31:0] imm = 32'h0;
    logic [31:0] pcOut;
    logic        flushOut;
    logic        redirectOut;
    logic        misalignedOut;

    int errors = 0;
    int checks = 0;
    bit done = 1'b0;

    // Behavioural model: PC value, remaining cycles flush must stay high, pulses.
    logic [31:0] mPc = RESET_PC;
    int          mFlushLeft = 0;
    logic        mRedir = 1'b0;
    logic        mMis = 1'b0;

    branch_redirect_ctrl #(
        .RESET_PC(RESET_PC),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .stall_in(stall),
        .ex_valid_in(exValid),
        .opcode_6_to_2_in(opcode),
        .branch_taken_in(taken),
        .ex_pc_in(exPc),
        .rs1_in(rs1),
        .imm_in(imm),
        .pc_out(pcOut),
        .flush_out(flushOut),
        .redirect_out(redirectOut),
        .misaligned_out(misalignedOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] modelDest(input logic [4:0] op, input logic [31:0] pcV,
                                              input logic [31:0] rsV, input logic [31:0] immV,
                                              output logic mis);
        logic [31:0] base;
        base = (op == OP_JALR) ? rsV + immV : pcV + immV;
        if (op == OP_JALR) base = base - (base % 2);
`ifdef MISALIGN_TRAP_EN
        mis = (base % 4) != 0;
        return mis ? TRAP_VECTOR : base;
`else
        mis = 1'b0;
        return base - (base % 4);
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        logic        mis;
        logic [31:0] dest;
        if (rst) begin
            mPc = RESET_PC;
            mFlushLeft = 0;
            mRedir = 1'b0;
            mMis = 1'b0;
        end else begin
            mRedir = 1'b0;
            mMis = 1'b0;
            if (!stall) begin
                if (mFlushLeft > 0) begin
                    mPc = mPc + 32'd4;
                    mFlushLeft = mFlushLeft - 1;
                end else if (exValid && taken &&
                             (opcode == OP_JAL || opcode == OP_JALR || opcode == OP_BXX)) begin
                    dest = modelDest(opcode, exPc, rs1, imm, mis);
                    mPc = dest;
                    mMis = mis;
                    mRedir = 1'b1;
                    mFlushLeft = FLUSH_CYCLES;
                end else begin
                    mPc = mPc + 32'd4;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            checkOutput("model pc", pcOut, mPc);
            checkOutput("model flush", {31'b0, flushOut}, {31'b0, mFlushLeft > 0});
            checkOutput("model redirect", {31'b0, redirectOut}, {31'b0, mRedir});
            checkOutput("model misaligned", {31'b0, misalignedOut}, {31'b0, mMis});
        end
    end

    // Called at a negedge; drives inputs, advances one cycle and returns at the next negedge.
    task automatic applyStimulus(input logic s, input logic v, input logic [4:0] op, input logic t,
                                 input logic [31:0] p, input logic [31:0] r, input logic [31:0] i);
        stall = s; exValid = v; opcode = op; taken = t; exPc = p; rs1 = r; imm = i;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic s);
        applyStimulus(s, 1'b0, OP_ADD, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic pulseReset();
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset pc", pcOut, RESET_PC);
        checkOutput("async reset flush", {31'b0, flushOut}, 32'h0);
        checkOutput("async reset redirect", {31'b0, redirectOut}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] op;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Scenario 1: sequential fetch out of reset.
        checkOutput("t1 pc0", pcOut, 32'h0);
        idle(1'b0); checkOutput("t1 pc4", pcOut, 32'h4);
        idle(1'b0); checkOutput("t1 pc8", pcOut, 32'h8);
        idle(1'b0); checkOutput("t1 pcC", pcOut, 32'hC);
        checkOutput("t1 flush", {31'b0, flushOut}, 32'h0);

        // Scenario 2: taken Bxx, two-cycle flush.
        applyStimulus(1'b0, 1'b1, OP_BXX, 1'b1, 32'h100, 32'h0, 32'h40);
        checkOutput("t2 target", pcOut, 32'h140);
        checkOutput("t2 redirect", {31'b0, redirectOut}, 32'h1);
        checkOutput("t2 flush1", {31'b0, flushOut}, 32'h1);
        applyStimulus(1'b0, 1'b1, OP_BXX, 1'b1, 32'h900, 32'h0, 32'h40);
        checkOutput("t2 pc144", pcOut, 32'h144);
        checkOutput("t2 flush2", {31'b0, flushOut}, 32'h1);
        checkOutput("t2 no redirect", {31'b0, redirectOut}, 32'h0);
        idle(1'b0);
        checkOutput("t2 pc148", pcOut, 32'h148);
        checkOutput("t2 flush done", {31'b0, flushOut}, 32'h0);

        // Scenario 3: JALR clears bit 0.
        applyStimulus(1'b0, 1'b1, OP_JALR, 1'b1, 32'h0, 32'h2001, 32'h10);
        checkOutput("t3 target", pcOut, 32'h2010);
        checkOutput("t3 misaligned", {31'b0, misalignedOut}, 32'h0);
        idle(1'b0); idle(1'b0);

        // Scenario 4: stalled take, then stall inside the flush window.
        repeat (3) applyStimulus(1'b1, 1'b1, OP_BXX, 1'b1, 32'h300, 32'h0, 32'h20);
        checkOutput("t4 held", pcOut, 32'h2018);
        checkOutput("t4 no redirect", {31'b0, redirectOut}, 32'h0);
        applyStimulus(1'b0, 1'b1, OP_BXX, 1'b1, 32'h300, 32'h0, 32'h20);
        checkOutput("t4 target", pcOut, 32'h320);
        idle(1'b1); idle(1'b1);
        checkOutput("t4 stall hold", pcOut, 32'h320);
        checkOutput("t4 stall flush", {31'b0, flushOut}, 32'h1);
        idle(1'b0);
        checkOutput("t4 pc324", pcOut, 32'h324);
        checkOutput("t4 flush still", {31'b0, flushOut}, 32'h1);
        idle(1'b0);
        checkOutput("t4 flush end", {31'b0, flushOut}, 32'h0);

        // Scenario 5: JAL to a misaligned target.
        applyStimulus(1'b0, 1'b1, OP_JAL, 1'b1, 32'h100, 32'h0, 32'h2);
`ifdef MISALIGN_TRAP_EN
        checkOutput("t5 trap pc", pcOut, TRAP_VECTOR);
        checkOutput("t5 misaligned", {31'b0, misalignedOut}, 32'h1);
`else
        checkOutput("t5 aligned pc", pcOut, 32'h100);
        checkOutput("t5 misaligned", {31'b0, misalignedOut}, 32'h0);
`endif
        idle(1'b0); idle(1'b0);

        // Scenario 6: reset in the middle of a flush.
        applyStimulus(1'b0, 1'b1, OP_BXX, 1'b1, 32'h500, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, OP_BXX, 1'b1, 32'h700, 32'h0, 32'h0);
        checkOutput("t6 ignored take", pcOut, 32'h504);
        exValid = 1'b0; taken = 1'b0;
        pulseReset();
        idle(1'b0);
        checkOutput("t6 after reset", pcOut, 32'h4);
        checkOutput("t6 flush", {31'b0, flushOut}, 32'h0);

        // Scenario 7: PC increment wraps at the top of the address space.
        applyStimulus(1'b0, 1'b1, OP_BXX, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h4);
        checkOutput("t7 top", pcOut, 32'hFFFF_FFFC);
        idle(1'b0);
        checkOutput("t7 wrap", pcOut, 32'h0);
        idle(1'b0);

        // Randomized traffic; every cycle is checked by the model compare process.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: op = OP_JAL;
                1: op = OP_JALR;
                2: op = OP_BXX;
                default: op = 5'($urandom);
            endcase
            if ($urandom_range(0, 249) == 0) begin
                pulseReset();
            end else begin
                applyStimulus($urandom_range(0, 4) == 0, 1'($urandom), op, 1'($urandom),
                              ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : $urandom,
                              $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 64)) : $urandom);
            end
        end

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
